// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-input WIDTH-bit selector feeding a DEPTH-stage valid/ready pipeline.
// Out-of-range selects yield DEFAULT_VAL, flagged per beat and in a sticky bit.
module mux_n_pipe #(
  parameter int               WIDTH       = 16,
  parameter int               N_IN        = 5,
  parameter int               SEL_W       = 3,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic                  err_sticky,
  input  logic                  clr_err
);

  logic             vld    [DEPTH];
  logic [WIDTH-1:0] dat    [DEPTH];
  logic             err    [DEPTH];
  logic             rdy    [DEPTH+1];
  logic             up_vld [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic             up_err [DEPTH];

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  // Unused select codes fall through to DEFAULT_VAL rather than indexing past the bus.
  always_comb begin
    mux_data = DEFAULT_VAL;
    mux_err  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_data = in_bus[i*WIDTH +: WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  assign rdy[DEPTH] = out_ready;
  assign up_vld[0]  = in_valid;
  assign up_dat[0]  = mux_data;
  assign up_err[0]  = mux_err;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_rdy
      assign rdy[k] = !vld[k] || rdy[k+1];
    end
    for (k = 1; k < DEPTH; k++) begin : g_up
      assign up_vld[k] = vld[k-1];
      assign up_dat[k] = dat[k-1];
      assign up_err[k] = err[k-1];
    end
  endgenerate

  // Payload only moves with a valid upstream beat; bubbles just clear the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld[s] <= 1'b0;
        dat[s] <= '0;
        err[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        if (rdy[s]) begin
          vld[s] <= up_vld[s];
          if (up_vld[s]) begin
            dat[s] <= up_dat[s];
            err[s] <= up_err[s];
          end
        end
      end
    end
  end

  // A bad beat accepted in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_sticky <= 1'b0;
    else if (in_valid && rdy[0] && mux_err)
      err_sticky <= 1'b1;
    else if (clr_err)
      err_sticky <= 1'b0;
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign sel_err   = err[DEPTH-1];

endmodule
